pc_fetch_register: RTL and testbench

// - Program-counter stage of the MIPS fetch path. Holds the current PC and drives it to the external +4 word aligner (32-bit adder).
// - Takes the aligner's result back on pc_plus4 and selects the next PC: sequential, branch, jump or jump-register.
// - Absorbs control-flow redirects that arrive while fetch is stalled, and applies them when the stall releases.

---
 rtl/pc_fetch_register_if.sv | 47 ++++
 rtl/pc_fetch_register.sv | 174 +++++++++++++++++
 tb/tb_pc_fetch_register.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_register_if.sv
// pc_fetch_register_if: fetch-stage PC bus.
// Bundles the stall/redirect inputs, the pc+4 return path from the external
// aligner and the PC-side outputs. With ALIGN_CHECK_EN defined the bus also
// carries the address-alignment fault report (addr_err / bad_addr).
// master = the fetch controller / pipeline side, slave = pc_fetch_register.
interface pc_fetch_register_if;
  logic        stall;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        redirect_pending;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;
  logic [31:0] bad_addr;

  modport master (
    output stall, pc_plus4, branch_taken, branch_offset,
           jump, jump_index, jump_reg, jr_addr,
    input  pc, pc_valid, flush, redirect_pending, addr_err, bad_addr
  );

  modport slave (
    input  stall, pc_plus4, branch_taken, branch_offset,
           jump, jump_index, jump_reg, jr_addr,
    output pc, pc_valid, flush, redirect_pending, addr_err, bad_addr
  );
`else
  modport master (
    output stall, pc_plus4, branch_taken, branch_offset,
           jump, jump_index, jump_reg, jr_addr,
    input  pc, pc_valid, flush, redirect_pending
  );

  modport slave (
    input  stall, pc_plus4, branch_taken, branch_offset,
           jump, jump_index, jump_reg, jr_addr,
    output pc, pc_valid, flush, redirect_pending
  );
`endif
endinterface

// File: rtl/pc_fetch_register.sv
// pc_fetch_register: program-counter stage of the MIPS fetch path.
// Holds the current PC, drives it to the external +4 aligner and picks the
// next PC from sequential / branch / jump / jump-register sources
// (priority jump_reg > jump > branch_taken). Redirects that arrive while
// stalled are parked in a single pending slot (newest wins) and released on
// the first unstalled edge.
// Optional feature macro: ALIGN_CHECK_EN -- a JR target with [1:0] != 00
// loads EXC_VECTOR instead, pulses addr_err and captures bad_addr.
module pc_fetch_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef ALIGN_CHECK_EN
  ,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_register_if.slave     bus
);

  // Branch target: sequential PC plus the sign-extended word offset.
  function automatic logic [31:0] branch_target(
    input logic        [31:0] seq_pc,
    input logic signed [15:0] offset
  );
    logic signed [31:0] disp;
    disp = {{14{offset[15]}}, offset, 2'b00};
    return seq_pc + disp;
  endfunction

  // Jump target: keep the 256 MB region of the sequential PC.
  function automatic logic [31:0] jump_target(
    input logic [31:0] seq_pc,
    input logic [25:0] index
  );
    return {seq_pc[31:28], index, 2'b00};
  endfunction

`ifdef ALIGN_CHECK_EN
  // A word fetch address must have its two low bits clear.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction
`endif

  // Architectural state.
  logic [31:0] pc_p0;
  logic        pc_valid_p0;
  logic        flush_p0;
  logic        pend_vld_p0;
  logic [31:0] pend_tgt_p0;
`ifdef ALIGN_CHECK_EN
  logic        pend_jr_p0;
  logic        addr_err_p0;
  logic [31:0] bad_addr_p0;
`endif

  // Redirect decode of the current strobes.
  logic        strobe;
  logic [31:0] strobe_tgt;
`ifdef ALIGN_CHECK_EN
  logic        strobe_jr;
`endif

  // Load selection for the coming edge.
  logic        load;
  logic [31:0] load_tgt;
`ifdef ALIGN_CHECK_EN
  logic        load_jr;
  logic        load_fault;
`endif

  // ---- stage 0: redirect decode (priority jump_reg > jump > branch) ----
  // Resolve coincident strobes to one target; lower priorities are dropped.
  always_comb begin
    strobe     = bus.jump_reg | bus.jump | bus.branch_taken;
    strobe_tgt = branch_target(bus.pc_plus4, bus.branch_offset);
`ifdef ALIGN_CHECK_EN
    strobe_jr  = 1'b0;
`endif
    if (bus.jump_reg) begin
      strobe_tgt = bus.jr_addr;
`ifdef ALIGN_CHECK_EN
      strobe_jr  = 1'b1;
`endif
    end else if (bus.jump) begin
      strobe_tgt = jump_target(bus.pc_plus4, bus.jump_index);
    end
  end

  // ---- stage 0: next-PC source selection ----
  // A live strobe beats a parked redirect; nothing loads while stalled.
  always_comb begin
    load     = 1'b0;
    load_tgt = strobe_tgt;
`ifdef ALIGN_CHECK_EN
    load_jr  = strobe_jr;
`endif
    if (!bus.stall) begin
      if (strobe) begin
        load = 1'b1;
      end else if (pend_vld_p0) begin
        load     = 1'b1;
        load_tgt = pend_tgt_p0;
`ifdef ALIGN_CHECK_EN
        load_jr  = pend_jr_p0;
`endif
      end
    end
`ifdef ALIGN_CHECK_EN
    load_fault = load & load_jr & misaligned(load_tgt);
`endif
  end

  // ---- stage 0 -> p0 register boundary ----
  // PC, pending slot and status flags; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= RESET_VECTOR;
      pc_valid_p0 <= 1'b0;
      flush_p0    <= 1'b0;
      pend_vld_p0 <= 1'b0;
      pend_tgt_p0 <= 32'h0;
`ifdef ALIGN_CHECK_EN
      pend_jr_p0  <= 1'b0;
      addr_err_p0 <= 1'b0;
      bad_addr_p0 <= 32'h0;
`endif
    end else begin
      flush_p0 <= 1'b0;
`ifdef ALIGN_CHECK_EN
      addr_err_p0 <= 1'b0;
`endif
      if (!bus.stall) begin
        pc_valid_p0 <= 1'b1;
        // Either the parked redirect is consumed or a newer strobe overrides it.
        pend_vld_p0 <= 1'b0;
        if (load) begin
          flush_p0 <= 1'b1;
`ifdef ALIGN_CHECK_EN
          if (load_fault) begin
            pc_p0       <= EXC_VECTOR;
            addr_err_p0 <= 1'b1;
            bad_addr_p0 <= load_tgt;
          end else begin
            pc_p0 <= load_tgt;
          end
`else
          pc_p0 <= load_tgt;
`endif
        end else begin
          pc_p0 <= bus.pc_plus4;
        end
      end else if (strobe) begin
        // Stalled: park the newest redirect, overwriting any older one.
        pend_vld_p0 <= 1'b1;
        pend_tgt_p0 <= strobe_tgt;
`ifdef ALIGN_CHECK_EN
        pend_jr_p0  <= strobe_jr;
`endif
      end
    end
  end

  assign bus.pc               = pc_p0;
  assign bus.pc_valid         = pc_valid_p0;
  assign bus.flush            = flush_p0;
  assign bus.redirect_pending = pend_vld_p0;
`ifdef ALIGN_CHECK_EN
  assign bus.addr_err         = addr_err_p0;
  assign bus.bad_addr         = bad_addr_p0;
`endif

endmodule

// File: tb/tb_pc_fetch_register.sv
// tb_pc_fetch_register: directed scenarios plus randomized traffic checked
// against a behavioural PC model (queue-based pending slot).
module tb_pc_fetch_register;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h8000_0180;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_fetch_register_if bus ();

  // External +4 aligner.
  assign bus.pc_plus4 = bus.pc + 32'd4;

  pc_fetch_register dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  typedef struct {
    logic [31:0] t;
    bit          jr;
  } pend_t;

  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_flush;
  bit          m_err;
  logic [31:0] m_bad;
  pend_t       m_pend[$];

  // Apply a redirect target to the model PC.
  task automatic model_load(input logic [31:0] t, input bit jr);
    m_flush = 1'b1;
`ifdef ALIGN_CHECK_EN
    if (jr && (t % 4) != 0) begin
      m_pc  = EXC_PC;
      m_err = 1'b1;
      m_bad = t;
    end else begin
      m_pc = t;
    end
`else
    m_pc = t;
`endif
  endtask

  // Advance one clock; update the model from the inputs seen at the edge,
  // then settle just after the edge.
  task automatic step();
    int          off;
    bit          has;
    logic [31:0] tgt;
    bit          jr;
    pend_t       e;
    @(posedge clk);
    if (rst) begin
      m_pc    = RST_PC;
      m_valid = 1'b0;
      m_flush = 1'b0;
      m_err   = 1'b0;
      m_bad   = 32'h0;
      m_pend.delete();
    end else begin
      m_flush = 1'b0;
      m_err   = 1'b0;
      has = bus.jump_reg || bus.jump || bus.branch_taken;
      jr  = 1'b0;
      off = $signed(bus.branch_offset);
      if (bus.jump_reg) begin
        tgt = bus.jr_addr;
        jr  = 1'b1;
      end else if (bus.jump) begin
        tgt = ((m_pc + 32'd4) & 32'hF000_0000) + 32'(bus.jump_index) * 32'd4;
      end else begin
        tgt = m_pc + 32'd4 + 32'(off * 4);
      end
      if (!bus.stall) begin
        m_valid = 1'b1;
        if (has) begin
          m_pend.delete();
          model_load(tgt, jr);
        end else if (m_pend.size() != 0) begin
          e = m_pend.pop_front();
          model_load(e.t, e.jr);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (has) begin
        m_pend.delete();
        e.t  = tgt;
        e.jr = jr;
        m_pend.push_back(e);
      end
    end
    #1;
  endtask

  task automatic clr_strobes();
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'h0;
    bus.jump          = 1'b0;
    bus.jump_index    = 26'h0;
    bus.jump_reg      = 1'b0;
    bus.jr_addr       = 32'h0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.stall = 1'b0;
    clr_strobes();
    step();
    step();
    n_checks++; if (bus.pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", bus.pc, RST_PC); else n_pass++;
    n_checks++; if (bus.pc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.pc_valid); else n_pass++;
    n_checks++; if (bus.flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush); else n_pass++;
    n_checks++; if (bus.redirect_pending !== 1'b0) $display("FAIL reset_pend: got %b want 0", bus.redirect_pending); else n_pass++;
`ifdef ALIGN_CHECK_EN
    n_checks++; if ({bus.addr_err, bus.bad_addr} !== 33'h0) $display("FAIL reset_err: got %b/%h want 0/0", bus.addr_err, bus.bad_addr); else n_pass++;
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_pc = 32'(i * 4);
      n_checks++; if (bus.pc !== exp_pc) $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, exp_pc); else n_pass++;
      n_checks++; if ({bus.pc_valid, bus.flush} !== 2'b10) $display("FAIL seq_flags%0d: got valid=%b flush=%b want 1/0", i, bus.pc_valid, bus.flush); else n_pass++;
    end
  endtask

  task automatic test_branch();
    bus.jump_reg = 1'b1;
    bus.jr_addr  = 32'h0000_0100;
    step();
    n_checks++; if (bus.pc !== 32'h100) $display("FAIL br_setup_pc: got %h want 00000100", bus.pc); else n_pass++;
    clr_strobes();
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'hFFFE;
    step();
    n_checks++; if (bus.pc !== 32'h0FC) $display("FAIL br_pc: got %h want 000000fc", bus.pc); else n_pass++;
    n_checks++; if (bus.flush !== 1'b1) $display("FAIL br_flush: got %b want 1", bus.flush); else n_pass++;
    clr_strobes();
    step();
    n_checks++; if ({bus.pc, bus.flush} !== {32'h100, 1'b0}) $display("FAIL br_after: got pc=%h flush=%b want 00000100/0", bus.pc, bus.flush); else n_pass++;
  endtask

  task automatic test_jump_stall();
    bus.stall      = 1'b1;
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000_0040;
    step();
    clr_strobes();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({bus.pc, bus.flush, bus.redirect_pending} !== {32'h100, 1'b0, 1'b1})
        $display("FAIL js_hold%0d: got pc=%h flush=%b pend=%b want 00000100/0/1", i, bus.pc, bus.flush, bus.redirect_pending); else n_pass++;
      if (i < 2) step();
    end
    bus.stall = 1'b0;
    step();
    n_checks++; if ({bus.pc, bus.flush, bus.redirect_pending} !== {32'h100, 1'b1, 1'b0})
      $display("FAIL js_release: got pc=%h flush=%b pend=%b want 00000100/1/0", bus.pc, bus.flush, bus.redirect_pending); else n_pass++;
    step();
    n_checks++; if ({bus.pc, bus.flush} !== {32'h104, 1'b0}) $display("FAIL js_after: got pc=%h flush=%b want 00000104/0", bus.pc, bus.flush); else n_pass++;
  endtask

  task automatic test_priority();
    bus.jump_reg      = 1'b1;
    bus.jr_addr       = 32'h0000_0400;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0010;
    step();
    n_checks++; if (bus.pc !== 32'h400) $display("FAIL prio_jr: got %h want 00000400", bus.pc); else n_pass++;
    clr_strobes();
    bus.jump          = 1'b1;
    bus.jump_index    = 26'h000_0123;
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0004;
    step();
    n_checks++; if (bus.pc !== 32'h48C) $display("FAIL prio_j: got %h want 0000048c", bus.pc); else n_pass++;
    clr_strobes();
  endtask

  task automatic test_pending_overwrite();
    bus.jump_reg = 1'b1;
    bus.jr_addr  = 32'h0000_1000;
    step();
    clr_strobes();
    bus.stall      = 1'b1;
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000_0080;
    step();
    clr_strobes();
    bus.branch_taken  = 1'b1;
    bus.branch_offset = 16'h0010;
    step();
    n_checks++; if ({bus.pc, bus.redirect_pending} !== {32'h1000, 1'b1}) $display("FAIL ow_hold: got pc=%h pend=%b want 00001000/1", bus.pc, bus.redirect_pending); else n_pass++;
    clr_strobes();
    bus.stall = 1'b0;
    step();
    n_checks++; if ({bus.pc, bus.flush, bus.redirect_pending} !== {32'h1044, 1'b1, 1'b0})
      $display("FAIL ow_release: got pc=%h flush=%b pend=%b want 00001044/1/0", bus.pc, bus.flush, bus.redirect_pending); else n_pass++;
  endtask

  task automatic test_reset_pending();
    bus.stall      = 1'b1;
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000_0200;
    step();
    clr_strobes();
    n_checks++; if (bus.redirect_pending !== 1'b1) $display("FAIL rp_pend: got %b want 1", bus.redirect_pending); else n_pass++;
    rst = 1'b1;
    step();
    n_checks++; if ({bus.pc, bus.redirect_pending, bus.pc_valid} !== {RST_PC, 1'b0, 1'b0})
      $display("FAIL rp_reset: got pc=%h pend=%b valid=%b want 00000000/0/0", bus.pc, bus.redirect_pending, bus.pc_valid); else n_pass++;
    rst       = 1'b0;
    bus.stall = 1'b0;
    step();
    n_checks++; if ({bus.pc, bus.flush} !== {32'h4, 1'b0}) $display("FAIL rp_after: got pc=%h flush=%b want 00000004/0", bus.pc, bus.flush); else n_pass++;
  endtask

`ifdef ALIGN_CHECK_EN
  task automatic test_align();
    bus.jump_reg = 1'b1;
    bus.jr_addr  = 32'h0000_0402;
    step();
    clr_strobes();
    n_checks++; if ({bus.pc, bus.flush, bus.addr_err, bus.bad_addr} !== {EXC_PC, 1'b1, 1'b1, 32'h402})
      $display("FAIL al_imm: got pc=%h flush=%b err=%b bad=%h want 80000180/1/1/00000402", bus.pc, bus.flush, bus.addr_err, bus.bad_addr); else n_pass++;
    step();
    n_checks++; if ({bus.pc, bus.addr_err, bus.bad_addr} !== {EXC_PC + 32'd4, 1'b0, 32'h402})
      $display("FAIL al_pulse: got pc=%h err=%b bad=%h want 80000184/0/00000402", bus.pc, bus.addr_err, bus.bad_addr); else n_pass++;
    bus.stall    = 1'b1;
    bus.jump_reg = 1'b1;
    bus.jr_addr  = 32'h0000_1003;
    step();
    clr_strobes();
    bus.stall = 1'b0;
    step();
    n_checks++; if ({bus.pc, bus.addr_err, bus.bad_addr} !== {EXC_PC, 1'b1, 32'h1003})
      $display("FAIL al_pend: got pc=%h err=%b bad=%h want 80000180/1/00001003", bus.pc, bus.addr_err, bus.bad_addr); else n_pass++;
    bus.jump_reg = 1'b1;
    bus.jr_addr  = 32'h0000_2000;
    step();
    clr_strobes();
    n_checks++; if ({bus.pc, bus.addr_err} !== {32'h2000, 1'b0}) $display("FAIL al_ok: got pc=%h err=%b want 00002000/0", bus.pc, bus.addr_err); else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst               = ($urandom_range(0, 39) == 0);
      bus.stall         = ($urandom_range(0, 2) == 0);
      bus.jump_reg      = ($urandom_range(0, 4) == 0);
      bus.jump          = ($urandom_range(0, 4) == 0);
      bus.branch_taken  = ($urandom_range(0, 3) == 0);
      bus.branch_offset = 16'($urandom);
      bus.jump_index    = 26'($urandom);
      bus.jr_addr       = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      step();
      n_checks++; if (bus.pc !== m_pc) $display("FAIL rnd_pc@%0d: got %h want %h", i, bus.pc, m_pc); else n_pass++;
      n_checks++; if ({bus.pc_valid, bus.flush, bus.redirect_pending} !== {m_valid, m_flush, (m_pend.size() != 0)})
        $display("FAIL rnd_flags@%0d: got v/f/p=%b%b%b want %b%b%b", i, bus.pc_valid, bus.flush, bus.redirect_pending,
                 m_valid, m_flush, (m_pend.size() != 0)); else n_pass++;
`ifdef ALIGN_CHECK_EN
      n_checks++; if ({bus.addr_err, bus.bad_addr} !== {m_err, m_bad})
        $display("FAIL rnd_err@%0d: got %b/%h want %b/%h", i, bus.addr_err, bus.bad_addr, m_err, m_bad); else n_pass++;
`endif
    end
    rst = 1'b0;
    clr_strobes();
    bus.stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_stall();
    test_priority();
    test_pending_overwrite();
    test_reset_pending();
`ifdef ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
